aes_key_scheduler: RTL and testbench
====================================

AES_KEY_SCHEDULER -- requirements
Module: aes_key_scheduler

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port n_rst, input, 1, reset that is synchronous and active-low.
REQ-003 SHALL have port key_load, input, 1, a start-expansion pulse that is sampled on each rising clk edge.
REQ-004 SHALL have port key_in, input, 128, the AES-128 cipher key; byte 0 is key_in[127:120] and word w0 is key_in[127:96].
REQ-005 SHALL have port read_addr, input, 5, the round-key index requested by the AES data path.
REQ-006 SHALL have port round_key_input, output, 128, the round key selected by read_addr.
REQ-007 SHALL have port round_key_0, output, 128, a permanent copy of round key 0.
REQ-008 SHALL have port keys_ready, output, 1, high while all 11 round keys are valid.
REQ-009 SHALL have port busy, output, 1, high while expansion is in progress.

Function
REQ-010 SHALL hold 11 round keys rk[0..10] of 128 bits each in registers.
REQ-011 SHALL implement an FSM with states IDLE, EXPAND and DONE.
REQ-012 SHALL act on key_load=1 in IDLE or DONE at edge E0 by writing rk[0]<=key_in, round<=1, rcon<=8'h01, keys_ready<=0 and moving to EXPAND.
REQ-013 SHALL compute one round key per edge in EXPAND, rk[round] from rk[round-1], per FIPS-197.
REQ-014 SHALL compute the round words as: w0'=w0^SubWord(RotWord(w3))^{rcon,24'h0}, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-015 SHALL update rcon by xtime each round (01,02,04,08,10,20,40,80,1B,36), where xtime = shift left 1, XOR 8'h1B on carry-out.
REQ-016 SHALL write rk[10] at edge E10, move to DONE and set keys_ready=1, so keys_ready is high for the first time in the cycle after E10.
REQ-017 SHALL hold busy=1 exactly while in EXPAND, which is 10 cycles.
REQ-018 SHALL ignore key_load while in EXPAND; no restart, and no change to round or rcon.
REQ-019 SHALL, on key_load in DONE, restart per REQ-012, with keys_ready low from the next cycle.
REQ-020 SHALL drive round_key_input combinationally as rk[read_addr] for read_addr 0..10 and 128'h0 for read_addr 11..31.
REQ-021 SHALL drive round_key_0 combinationally from rk[0].
REQ-022 SHALL let reads during EXPAND return current register contents, which may be partially updated; consumers gate on keys_ready.
REQ-023 SHALL, when key_load and n_rst=0 occur on the same edge, give reset priority.

Reset
REQ-024 SHALL, when n_rst=0 at a rising edge, set state=IDLE, round=0, rcon=8'h01 and all rk[0..10]=128'h0.
REQ-025 SHALL, on that reset, set keys_ready=0 and busy=0, so round_key_input and round_key_0 read 128'h0.
REQ-026 SHALL make reset during EXPAND abort expansion immediately with no partial keys retained.

Structure
REQ-027 SHALL take the following from shared package aes_pkg: the state typedef (IDLE/EXPAND/DONE), NUM_ROUNDS=10, KEY_W=128 and the 8'h1B reduction constant.
REQ-028 SHALL instantiate sub-module aes_sbox (combinational 8-bit forward S-box) four times, once per SubWord byte.
REQ-029 SHALL contain no other sub-modules; the FSM, rcon, the XOR chain and the key register file are in this module.

Verification
REQ-030 SHALL be covered by a FIPS-197 A.1 scenario: key_in=2b7e151628aed2a6abf7158809cf4f3c with a 1-cycle key_load -> after 10 cycles keys_ready=1; read_addr=1 gives a0fafe1788542cb123a339392a6c7605; read_addr=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; round_key_0 equals key_in.
REQ-031 SHALL be covered by a timing scenario: key_load at E0 -> busy=1 in cycles E0+1..E10 and keys_ready rises after E10, not before.
REQ-032 SHALL be covered by a key_load-during-EXPAND scenario: pulse key_load with a different key at E4 -> results still match the original key and keys_ready still follows E10.
REQ-033 SHALL be covered by an out-of-range read scenario: read_addr=11, 20 and 31 in DONE -> round_key_input=128'h0.
REQ-034 SHALL be covered by a reset-mid-expansion scenario: n_rst=0 at E5 -> next cycle state IDLE, keys_ready=0, busy=0 and every read_addr returns 0; a new key_load then expands correctly.
REQ-035 SHALL be covered by a reload-from-DONE scenario: key_load with key 000102030405060708090a0b0c0d0e0f -> keys_ready drops next cycle; rk[10] becomes 13111d7fe3944a17f307a78b4d2b30c5.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key schedule types, constants and GF(2^8) helper
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } key_state_t;

  localparam int          NUM_ROUNDS = 10;
  localparam int          KEY_W      = 128;
  localparam logic [7:0]  XTIME_POLY = 8'h1B;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box
// Ports:
//   in_byte  - byte to substitute
//   out_byte - S-box output
// Computed rather than tabulated: multiplicative inverse as x^254, then the
// affine transform with constant 8'h63 (0 maps to 0 before the affine step).
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // x^254 = x^2 * x^4 * ... * x^128
  always_comb begin
    sq  = in_byte;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
  end

  assign out_byte = inv
                  ^ {inv[6:0], inv[7]}
                  ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/aes_key_scheduler.sv
// rtl/aes_key_scheduler.sv - iterative AES-128 key expansion into an 11-entry round key file
// Ports:
//   clk             - clock, rising edge
//   n_rst           - synchronous active-low reset
//   key_load        - start expansion of key_in (ignored while expanding)
//   key_in          - cipher key, word w0 in [127:96]
//   read_addr       - round key index, 0..10 valid, 11..31 read as zero
//   round_key_input - rk[read_addr]
//   round_key_0     - rk[0]
//   keys_ready      - all round keys valid
//   busy            - expansion in progress
module aes_key_scheduler
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_in,
  input  logic [4:0]       read_addr,
  output logic [KEY_W-1:0] round_key_input,
  output logic [KEY_W-1:0] round_key_0,
  output logic             keys_ready,
  output logic             busy
);

  key_state_t       state, state_next;
  logic [3:0]       round;
  logic [7:0]       rcon;
  logic [KEY_W-1:0] rk [0:NUM_ROUNDS];

  logic [KEY_W-1:0] prev_key;
  logic [KEY_W-1:0] next_key;
  logic [31:0]      rot_word;
  logic [31:0]      sub_word;
  logic [31:0]      w0n, w1n, w2n, w3n;

  // rk[round-1]; round is 1..10 while expanding
  always_comb begin
    prev_key = '0;
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      if (round == 4'(i + 1)) prev_key = rk[i];
    end
  end

  assign rot_word = {prev_key[23:0], prev_key[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_word[8*g +: 8]),
      .out_byte (sub_word[8*g +: 8])
    );
  end

  assign w0n      = prev_key[127:96] ^ sub_word ^ {rcon, 24'h0};
  assign w1n      = prev_key[95:64]  ^ w0n;
  assign w2n      = prev_key[63:32]  ^ w1n;
  assign w3n      = prev_key[31:0]   ^ w2n;
  assign next_key = {w0n, w1n, w2n, w3n};

  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (key_load) state_next = EXPAND;
      EXPAND:     if (round == 4'(NUM_ROUNDS)) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
      round <= 4'd0;
      rcon  <= 8'h01;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (key_load) begin
            rk[0] <= key_in;
            round <= 4'd1;
            rcon  <= 8'h01;
          end
        end
        EXPAND: begin
          for (int i = 1; i <= NUM_ROUNDS; i++) begin
            if (round == 4'(i)) rk[i] <= next_key;
          end
          round <= round + 4'd1;
          rcon  <= xtime(rcon);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    round_key_input = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (read_addr == 5'(i)) round_key_input = rk[i];
    end
  end

  assign round_key_0 = rk[0];
  assign keys_ready  = (state == DONE);
  assign busy        = (state == EXPAND);

endmodule

// File: tb/tb_aes_key_scheduler.sv
// tb/tb_aes_key_scheduler.sv - scoreboard testbench for aes_key_scheduler
module tb_aes_key_scheduler;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         key_load;
  logic [127:0] key_in;
  logic [4:0]   read_addr;
  logic [127:0] round_key_input;
  logic [127:0] round_key_0;
  logic         keys_ready;
  logic         busy;

  always #5 clk = ~clk;

  aes_key_scheduler dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .key_load        (key_load),
    .key_in          (key_in),
    .read_addr       (read_addr),
    .round_key_input (round_key_input),
    .round_key_0     (round_key_0),
    .keys_ready      (keys_ready),
    .busy            (busy)
  );

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_A1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY_A2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] KEY_A9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] KEY_A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] KEY_B10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef enum int {K_RKI, K_RK0, K_READY, K_BUSY} kind_t;

  typedef struct {
    string        name;
    kind_t        kind;
    logic [127:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor: outputs are combinational/steady mid-cycle, so every expectation
  // queued since the last posedge is checked on the following negedge.
  always @(negedge clk) begin
    exp_t         e;
    logic [127:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RKI:   act = round_key_input;
        K_RK0:   act = round_key_0;
        K_READY: act = {127'h0, keys_ready};
        default: act = {127'h0, busy};
      endcase
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input string name, input kind_t kind, input logic [127:0] val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  // One read per cycle so read_addr is stable when the monitor samples it.
  task automatic chk_read(input string name, input logic [4:0] addr, input logic [127:0] val);
    step();
    read_addr = addr;
    expect_sig(name, K_RKI, val);
  endtask

  // Pulse key_load over edge E0 and walk edges E1..E10, checking busy/ready
  // in each cycle between them; optionally pulse another key_load into E4.
  task automatic load_and_expand(input logic [127:0] key, input bit pulse_e4,
                                 input logic [127:0] other_key);
    key_in   = key;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      expect_sig($sformatf("busy_c%0d", k), K_BUSY, 128'd1);
      expect_sig($sformatf("ready_c%0d", k), K_READY, 128'd0);
      if (pulse_e4 && k == 4) begin
        key_in   = other_key;
        key_load = 1'b1;
      end
      step();
      key_load = 1'b0;
    end
    expect_sig("busy_done", K_BUSY, 128'd0);
    expect_sig("ready_done", K_READY, 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst     = 1'b0;
    key_load  = 1'b0;
    key_in    = '0;
    read_addr = 5'd0;
    step();
    // key_load asserted together with reset must be ignored
    key_in   = KEY_A;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    step();
    expect_sig("rst_busy", K_BUSY, 128'd0);
    expect_sig("rst_ready", K_READY, 128'd0);
    expect_sig("rst_rk0", K_RK0, 128'h0);
    expect_sig("rst_rki0", K_RKI, 128'h0);
    n_rst = 1'b1;
    step();
    expect_sig("idle_busy", K_BUSY, 128'd0);
    expect_sig("idle_rk0", K_RK0, 128'h0);

    // FIPS-197 A.1 with a competing key_load at E4
    load_and_expand(KEY_A, 1'b1, KEY_B);
    chk_read("a_rk0", 5'd0, KEY_A);
    chk_read("a_rk1", 5'd1, KEY_A1);
    chk_read("a_rk2", 5'd2, KEY_A2);
    chk_read("a_rk9", 5'd9, KEY_A9);
    chk_read("a_rk10", 5'd10, KEY_A10);
    expect_sig("a_round_key_0", K_RK0, KEY_A);
    chk_read("oor_11", 5'd11, 128'h0);
    chk_read("oor_20", 5'd20, 128'h0);
    chk_read("oor_31", 5'd31, 128'h0);
    expect_sig("oor_ready", K_READY, 128'd1);

    // reload from DONE
    step();
    load_and_expand(KEY_B, 1'b0, '0);
    chk_read("b_rk1", 5'd1, KEY_B1);
    chk_read("b_rk10", 5'd10, KEY_B10);
    expect_sig("b_round_key_0", K_RK0, KEY_B);

    // reset in the cycle before E5
    step();
    key_in   = KEY_A;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    expect_sig("mid_busy", K_BUSY, 128'd1);
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    expect_sig("ra_busy", K_BUSY, 128'd0);
    expect_sig("ra_ready", K_READY, 128'd0);
    expect_sig("ra_rk0", K_RK0, 128'h0);
    for (int a = 0; a <= 10; a++) chk_read($sformatf("ra_rk%0d", a), 5'(a), 128'h0);
    step();
    expect_sig("ra_idle_busy", K_BUSY, 128'd0);

    // fresh expansion after reset
    load_and_expand(KEY_B, 1'b0, '0);
    chk_read("c_rk0", 5'd0, KEY_B);
    chk_read("c_rk1", 5'd1, KEY_B1);
    chk_read("c_rk10", 5'd10, KEY_B10);

    step();
    step();
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
